// File: rtl/rv_alu_arbiter.sv
// Two-port arbiter sharing one external combinational ALU.
// Each port has a valid/ready request handshake and a one-entry registered response slot.
module rv_alu_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int OP_W      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid_i,
    input  logic [31:0]     req0_opr_a_i,
    input  logic [31:0]     req0_opr_b_i,
    input  logic [OP_W-1:0] req0_op_i,
    output logic            req0_ready_o,
    output logic            rsp0_valid_o,
    output logic [31:0]     rsp0_res_o,
    input  logic            rsp0_ready_i,
    input  logic            req1_valid_i,
    input  logic [31:0]     req1_opr_a_i,
    input  logic [31:0]     req1_opr_b_i,
    input  logic [OP_W-1:0] req1_op_i,
    output logic            req1_ready_o,
    output logic            rsp1_valid_o,
    output logic [31:0]     rsp1_res_o,
    input  logic            rsp1_ready_i,
    output logic [31:0]     alu_opr_a_o,
    output logic [31:0]     alu_opr_b_o,
    output logic [OP_W-1:0] alu_op_o,
    input  logic [31:0]     alu_res_i,
    output logic            busy_o
);
    logic        elig0, elig1, gnt0, gnt1;
    logic        last_gnt_q, last_gnt_d;
    logic        rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp0_res_q, rsp0_res_d, rsp1_res_q, rsp1_res_d;

    // A slot whose response is draining this cycle can accept a new grant.
    always_comb begin
        elig0 = req0_valid_i & (~rsp0_valid_q | rsp0_ready_i);
        elig1 = req1_valid_i & (~rsp1_valid_q | rsp1_ready_i);
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        if (!reset) begin
            if (elig0 && elig1) begin
                if (PRIO_MODE != 0 || last_gnt_q) gnt0 = 1'b1;
                else                              gnt1 = 1'b1;
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
    end

    always_comb begin
        alu_opr_a_o = '0;
        alu_opr_b_o = '0;
        alu_op_o    = '0;
        if (gnt0) begin
            alu_opr_a_o = req0_opr_a_i;
            alu_opr_b_o = req0_opr_b_i;
            alu_op_o    = req0_op_i;
        end else if (gnt1) begin
            alu_opr_a_o = req1_opr_a_i;
            alu_opr_b_o = req1_opr_b_i;
            alu_op_o    = req1_op_i;
        end
    end

    always_comb begin
        last_gnt_d   = last_gnt_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp0_res_d   = rsp0_res_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_res_d   = rsp1_res_q;
        if (gnt0)      last_gnt_d = 1'b0;
        else if (gnt1) last_gnt_d = 1'b1;
        if (gnt0) begin
            rsp0_valid_d = 1'b1;
            rsp0_res_d   = alu_res_i;
        end else if (rsp0_ready_i) begin
            rsp0_valid_d = 1'b0;
        end
        if (gnt1) begin
            rsp1_valid_d = 1'b1;
            rsp1_res_d   = alu_res_i;
        end else if (rsp1_ready_i) begin
            rsp1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q   <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp0_res_q   <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_res_q   <= '0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_res_q   <= rsp0_res_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_res_q   <= rsp1_res_d;
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign rsp0_valid_o = rsp0_valid_q;
    assign rsp0_res_o   = rsp0_res_q;
    assign rsp1_valid_o = rsp1_valid_q;
    assign rsp1_res_o   = rsp1_res_q;
    assign busy_o       = rsp0_valid_q | rsp1_valid_q | gnt0 | gnt1;
endmodule

// File: tb/tb_rv_alu_arbiter.sv
// Bench for rv_alu_arbiter: instance 0 round-robin, instance 1 fixed priority,
// each wrapped around a behavioural ALU and checked by a per-port result scoreboard.
module tb_rv_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv   [2][2];
    logic [31:0] ra   [2][2];
    logic [31:0] rb   [2][2];
    logic [3:0]  rop  [2][2];
    logic        rdy  [2][2];
    logic        rspv [2][2];
    logic [31:0] rres [2][2];
    logic        rr   [2][2];
    logic [31:0] alu_a [2];
    logic [31:0] alu_b [2];
    logic [3:0]  alu_op [2];
    logic [31:0] alu_res [2];
    logic        busy [2];

    int checks = 0;
    int errors = 0;

    // reference state: per-port pending flag, last winner, expected result FIFOs
    bit          pend [2][2];
    int          last [2] = '{1, 1};
    bit          acc  [2][2];
    logic [31:0] exp_q [4][$];
    bit          e [2];
    int          win;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rv_alu_arbiter #(.PRIO_MODE(g), .OP_W(4)) u_dut (
            .clk          (clk),
            .reset        (rst),
            .req0_valid_i (rv[g][0]),
            .req0_opr_a_i (ra[g][0]),
            .req0_opr_b_i (rb[g][0]),
            .req0_op_i    (rop[g][0]),
            .req0_ready_o (rdy[g][0]),
            .rsp0_valid_o (rspv[g][0]),
            .rsp0_res_o   (rres[g][0]),
            .rsp0_ready_i (rr[g][0]),
            .req1_valid_i (rv[g][1]),
            .req1_opr_a_i (ra[g][1]),
            .req1_opr_b_i (rb[g][1]),
            .req1_op_i    (rop[g][1]),
            .req1_ready_o (rdy[g][1]),
            .rsp1_valid_o (rspv[g][1]),
            .rsp1_res_o   (rres[g][1]),
            .rsp1_ready_i (rr[g][1]),
            .alu_opr_a_o  (alu_a[g]),
            .alu_opr_b_o  (alu_b[g]),
            .alu_op_o     (alu_op[g]),
            .alu_res_i    (alu_res[g]),
            .busy_o       (busy[g])
        );
        assign alu_res[g] = alu_f(alu_a[g], alu_b[g], alu_op[g]);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare against the reference, then advance it across the coming edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            for (int p = 0; p < 2; p++) e[p] = rv[g][p] && (!pend[g][p] || rr[g][p]);
            if (rst)               win = -1;
            else if (e[0] && e[1]) win = (g == 1) ? 0 : 1 - last[g];
            else if (e[0])         win = 0;
            else if (e[1])         win = 1;
            else                   win = -1;
            chk($sformatf("busy[%0d]", g), busy[g],
                pend[g][0] || pend[g][1] || win >= 0);
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("ready[%0d][%0d]", g, p), rdy[g][p], win == p);
                chk($sformatf("rsp_valid[%0d][%0d]", g, p), rspv[g][p], pend[g][p]);
                if (pend[g][p]) begin
                    chk($sformatf("sb_nonempty[%0d][%0d]", g, p), exp_q[g*2+p].size() != 0, 1);
                    if (exp_q[g*2+p].size() != 0) begin
                        chk($sformatf("rsp_res[%0d][%0d]", g, p), rres[g][p], exp_q[g*2+p][0]);
                        if (rr[g][p] && !rst) void'(exp_q[g*2+p].pop_front());
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                acc[g][p] = (win == p);
                if (rst) begin
                    pend[g][p] = 0;
                    exp_q[g*2+p].delete();
                end else if (win == p) begin
                    exp_q[g*2+p].push_back(alu_f(ra[g][p], rb[g][p], rop[g][p]));
                    pend[g][p] = 1;
                end else if (rr[g][p]) begin
                    pend[g][p] = 0;
                end
            end
            if (rst)           last[g] = 1;
            else if (win >= 0) last[g] = win;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setq(int g, int p, logic v, logic [31:0] a, logic [31:0] b, logic [3:0] op);
        rv[g][p] = v; ra[g][p] = a; rb[g][p] = b; rop[g][p] = op;
    endtask

    task automatic drive_rand(int pv, int pr, int gmask);
        for (int g = 0; g < 2; g++) begin
            if (gmask[g]) begin
                for (int p = 0; p < 2; p++) begin
                    if (!rv[g][p] || acc[g][p]) begin
                        rv[g][p]  = ($urandom % 100) < pv;
                        ra[g][p]  = ($urandom % 4 == 0) ? $urandom % 16 : $urandom;
                        rb[g][p]  = ($urandom % 4 == 0) ? $urandom % 16 : $urandom;
                        rop[g][p] = 4'($urandom % 5);
                    end
                    rr[g][p] = ($urandom % 100) < pr;
                end
            end
        end
    endtask

    task automatic idle(int n);
        for (int g = 0; g < 2; g++)
            for (int p = 0; p < 2; p++) begin
                rv[g][p] = 0; rr[g][p] = 1;
            end
        repeat (n) step();
    endtask

    initial begin
        for (int g = 0; g < 2; g++)
            for (int p = 0; p < 2; p++) begin
                setq(g, p, 0, 0, 0, 0);
                rr[g][p] = 1;
            end
        rst = 1;
        repeat (3) step();
        rst = 0;
        @(negedge clk);
        chk("reset_res0", rres[0][0], 0);
        chk("reset_res1", rres[1][1], 0);

        // single request on port 0: SUB 5-3
        step();
        setq(0, 0, 1, 5, 3, 1);
        @(negedge clk); chk("t1_ready", rdy[0][0], 1);
        step(); rv[0][0] = 0;
        @(negedge clk); chk("t1_valid", rspv[0][0], 1); chk("t1_res", rres[0][0], 2);

        // tie right after reset: port 0 first, then port 1
        step(); rst = 1;
        step(); rst = 0;
        setq(0, 0, 1, 7, 1, 0);
        setq(0, 1, 1, 32'hF0, 32'h3C, 2);
        @(negedge clk); chk("t2_p0_first", rdy[0][0], 1); chk("t2_p1_wait", rdy[0][1], 0);
        step(); rv[0][0] = 0;
        @(negedge clk); chk("t2_p1_next", rdy[0][1], 1); chk("t2_res0", rres[0][0], 8);
        step(); rv[0][1] = 0;
        @(negedge clk); chk("t2_valid1", rspv[0][1], 1); chk("t2_res1", rres[0][1], 32'h30);

        // continuous requests on both ports, responses always consumed
        repeat (24) begin step(); drive_rand(100, 100, 1); end
        idle(3);

        // port 0 blocked behind an unconsumed response
        rr[0][0] = 0; setq(0, 0, 1, 5, 6, 0);
        @(negedge clk); chk("t4_first", rdy[0][0], 1);
        step(); setq(0, 0, 1, 9, 9, 0); setq(0, 1, 1, 1, 2, 0);
        @(negedge clk); chk("t4_p0_blocked", rdy[0][0], 0); chk("t4_p1_served", rdy[0][1], 1);
        step(); setq(0, 1, 1, 3, 4, 1);
        @(negedge clk); chk("t4_p0_blocked2", rdy[0][0], 0); chk("t4_p1_served2", rdy[0][1], 1);
        step(); rv[0][1] = 0; rr[0][0] = 1;
        @(negedge clk); chk("t4_p0_drain_grant", rdy[0][0], 1);
        step(); rv[0][0] = 0;
        @(negedge clk); chk("t4_valid", rspv[0][0], 1); chk("t4_res", rres[0][0], 18);
        idle(2);

        // reset with a pending port 1 response and port 0 waiting
        rr[0][1] = 0; setq(0, 1, 1, 1, 1, 0);
        step(); rv[0][1] = 0; setq(0, 0, 1, 2, 2, 0); rst = 1;
        @(negedge clk); chk("t5_pending", rspv[0][1], 1);
        step(); rst = 0; setq(0, 1, 1, 4, 4, 0);
        @(negedge clk);
        chk("t5_v0_clr", rspv[0][0], 0); chk("t5_v1_clr", rspv[0][1], 0);
        chk("t5_res0_clr", rres[0][0], 0); chk("t5_p0_tie", rdy[0][0], 1);
        step(); rv[0][0] = 0;
        @(negedge clk); chk("t5_p1_next", rdy[0][1], 1);
        step(); rv[0][1] = 0; rr[0][1] = 1;
        idle(2);

        // fixed priority: port 1 starves until port 0 drops valid
        setq(1, 1, 1, 11, 22, 3);
        for (int c = 0; c < 6; c++) begin
            setq(1, 0, 1, 32'(c), 32'(c * 3), 4'(c % 5));
            @(negedge clk);
            chk("t6_p0_wins", rdy[1][0], 1); chk("t6_p1_starved", rdy[1][1], 0);
            step();
        end
        rv[1][0] = 0;
        @(negedge clk); chk("t6_p1_after_drop", rdy[1][1], 1);
        step(); rv[1][1] = 0;
        idle(2);

        // randomized traffic on both instances with occasional reset
        repeat (3000) begin
            step();
            rst = ($urandom % 150) == 0;
            drive_rand(70, 60, 3);
        end
        rst = 0;
        idle(4);
        for (int i = 0; i < 4; i++) chk($sformatf("sb_drained[%0d]", i), exp_q[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
